// File: rtl/dpfu_param.sv
// Instruction prefetch unit: burst fetches into a DEPTH-entry FIFO feeding the decoder.
// Define DPFU_BTFN_EN to enable static backward-taken prediction on JAL.
module dpfu_param #(
    parameter int          BURST    = 4,
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      mem_req,
    output logic [31:0]               mem_addr,
    output logic [$clog2(BURST):0]    mem_count,
    input  logic [32*BURST-1:0]       mem_rdata,
    input  logic                      mem_rvalid,
    input  logic                      mem_rdone,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      dec_ready,
    output logic                      dec_valid,
    output logic [31:0]               dec_instr,
    output logic [31:0]               dec_pc,
    output logic                      dec_pred_taken,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    // state | meaning
    // IDLE  | no request outstanding; issue one when a FIFO slot is free
    // REQ   | mem_req strobe cycle, address and count presented
    // WAIT  | request outstanding, response beat is pushed on arrival
    // DRAIN | request outstanding after a redirect, response beat is dropped
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int CW = $clog2(BURST) + 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_L = LW'(BURST);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [CW-1:0] req_count;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [LW-1:0] level;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic          pop;
    logic          push;
    logic [LW-1:0] free_now;
    logic [CW-1:0] live_count;
    logic [CW-1:0] push_n;
    logic [31:0]   next_fetch;
    logic          unused_inputs;

`ifdef DPFU_BTFN_EN
    logic [BURST-1:0] push_pred;
    logic             pred_q [DEPTH];
    logic             jal_found;
    logic [31:0]      lane;
`endif

    // Completion is signalled by mem_rvalid alone: one beat per request.
    assign unused_inputs = ^{mem_rdone, redirect_pc[1:0]};

    assign dec_valid  = (level != '0);
    assign fifo_level = level;
    assign dec_instr  = instr_q[rptr];
    assign dec_pc     = pc_q[rptr];

`ifdef DPFU_BTFN_EN
    assign dec_pred_taken = dec_valid & pred_q[rptr];
`else
    assign dec_pred_taken = 1'b0;
`endif

    assign pop  = dec_valid & dec_ready & ~redirect_valid;
    assign push = (state == S_WAIT) & mem_rvalid & ~redirect_valid;

    // A pop in the request cycle frees its slot before any push can land.
    assign free_now   = DEPTH_L - level + LW'(dec_valid & dec_ready);
    assign live_count = (free_now > BURST_L) ? CW'(BURST) : CW'(free_now);

    assign mem_req   = (state == S_REQ);
    assign mem_addr  = (state == S_REQ) ? fetch_pc   : req_addr;
    assign mem_count = (state == S_REQ) ? live_count : req_count;

    always_comb begin
        push_n     = req_count;
        next_fetch = req_addr + {{(30-CW){1'b0}}, req_count, 2'b00};
`ifdef DPFU_BTFN_EN
        push_pred = '0;
        jal_found = 1'b0;
        lane      = '0;
        for (int i = 0; i < BURST; i++) begin
            lane = mem_rdata[32*i +: 32];
            if (!jal_found && (i < int'(req_count)) &&
                (lane[6:0] == 7'b1101111) && lane[31]) begin
                jal_found    = 1'b1;
                push_n       = CW'(i + 1);
                push_pred[i] = 1'b1;
                next_fetch   = req_addr + 32'(4 * i) +
                               {{12{lane[31]}}, lane[19:12], lane[20], lane[30:21], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && (level != DEPTH_L))
                    state_nx = S_REQ;
            end
            S_REQ: begin
                state_nx = redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid)
                    state_nx = S_IDLE;
                else if (redirect_valid)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                // The drained beat retires the outstanding request even if a redirect coincides.
                if (mem_rvalid)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= '0;
            req_count <= '0;
            rptr      <= '0;
            wptr      <= '0;
            level     <= '0;
        end else begin
            state <= state_nx;
            if (state == S_REQ) begin
                req_addr  <= fetch_pc;
                req_count <= live_count;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rptr     <= '0;
                wptr     <= '0;
                level    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= next_fetch;
                    wptr     <= wptr + PW'(push_n);
                end
                if (pop)
                    rptr <= rptr + PW'(1);
                level <= level + (push ? LW'(push_n) : LW'(0)) - LW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < BURST; i++) begin
                if (i < int'(push_n)) begin
                    instr_q[wptr + PW'(i)] <= mem_rdata[32*i +: 32];
                    pc_q[wptr + PW'(i)]    <= req_addr + 32'(4 * i);
`ifdef DPFU_BTFN_EN
                    pred_q[wptr + PW'(i)]  <= push_pred[i];
`endif
                end
            end
        end
    end

endmodule
